// File: rtl/reg_file_pkg.sv
// Shared processor constants: ISA register-count figures and the register
// file defaults derived from them.
package reg_file_pkg;

    // ISA-visible general purpose register set
    localparam int unsigned ISA_NUM_REGS  = 8;
    localparam int unsigned ISA_REG_AW    = $clog2(ISA_NUM_REGS);
    localparam int unsigned ISA_XLEN      = 16;

    // Register file defaults track the ISA register set
    localparam int unsigned DEFAULT_WIDTH = ISA_XLEN;
    localparam int unsigned DEFAULT_DEPTH = ISA_NUM_REGS;
    localparam int unsigned DEFAULT_AW    = ISA_REG_AW;

    typedef logic [ISA_REG_AW-1:0] isa_reg_addr_t;
    typedef logic [ISA_XLEN-1:0]   isa_word_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_word.sv
// reg_word: one storage word of the register file.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high clear, wins over load
//   load - capture d on the next rising edge
//   d    - write data
//   q    - stored value
module reg_word #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear has priority so a write in the reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : reg_word

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, one write port, two combinational
// read ports, optional write-through forwarding and hardwired-zero r0.
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   R        - synchronous active-high reset, clears every word
//   WE/WA/WD - write enable, address, data
//   RA1/RA2  - read addresses
//   RD1/RD2  - read data (zero-latency)
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned AW      = DEFAULT_AW,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned ZERO_R0 = 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             WE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] WD,
    input  logic [AW-1:0]    RA1,
    input  logic [AW-1:0]    RA2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2
);

    logic [WIDTH-1:0] word_q  [DEPTH];
    logic [WIDTH-1:0] word_rd [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic             byp_en;
    logic [WIDTH-1:0] rd1_mux;
    logic [WIDTH-1:0] rd2_mux;

    // Write decode and storage; addresses >= DEPTH match no word and are dropped
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_r0_zero
            assign wr_sel[i]  = 1'b0;
            assign word_rd[i] = word_q[i] & {WIDTH{1'b0}};
        end else begin : g_live
            assign wr_sel[i]  = WE && (WA == AW'(i));
            assign word_rd[i] = word_q[i];
        end

        reg_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk  (CLK),
            .rst  (R),
            .load (wr_sel[i]),
            .d    (WD),
            .q    (word_q[i])
        );
    end

    // Read muxes; an address matching no word returns zero
    always_comb begin
        rd1_mux = '0;
        rd2_mux = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (RA1 == AW'(i)) begin
                rd1_mux = word_rd[i];
            end
            if (RA2 == AW'(i)) begin
                rd2_mux = word_rd[i];
            end
        end
    end

    // Forward only writes that will actually land (in range, not r0, no reset)
    assign byp_en = (BYPASS != 0) && !R && (|wr_sel);

    assign RD1 = (byp_en && (RA1 == WA)) ? WD : rd1_mux;
    assign RD2 = (byp_en && (RA2 == WA)) ? WD : rd2_mux;

endmodule : reg_file

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        CLK;
    logic        R;
    logic        WE;
    logic [2:0]  WA;
    logic [15:0] WD;
    logic [2:0]  RA1;
    logic [2:0]  RA2;

    logic [15:0] rd1_a,  rd2_a;
    logic [15:0] rd1_nb, rd2_nb;
    logic [15:0] rd1_nz, rd2_nz;
    logic [15:0] rd1_d6, rd2_d6;

    int passed = 0;
    int total  = 0;

    reg_file #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1), .ZERO_R0(1)) u_dut (
        .CLK(CLK), .R(R), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_a), .RD2(rd2_a)
    );

    reg_file #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(0), .ZERO_R0(1)) u_nobyp (
        .CLK(CLK), .R(R), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_nb), .RD2(rd2_nb)
    );

    reg_file #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1), .ZERO_R0(0)) u_nozero (
        .CLK(CLK), .R(R), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_nz), .RD2(rd2_nz)
    );

    reg_file #(.WIDTH(16), .DEPTH(6), .AW(3), .BYPASS(1), .ZERO_R0(1)) u_d6 (
        .CLK(CLK), .R(R), .WE(WE), .WA(WA), .WD(WD),
        .RA1(RA1), .RA2(RA2), .RD1(rd1_d6), .RD2(rd2_d6)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        r;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vec [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        R  = 1'b1;
        WE = 1'b0;
        tick();
        R  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        WE = 1'b1;
        WA = a;
        WD = d;
        tick();
        WE = 1'b0;
    endtask

    initial begin
        R = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;
        tick();

        //          r     we    wa    wd        ra1   ra2   e1        e2
        vec[0]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0000, 16'h0000};
        vec[1]  = '{1'b0, 1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd4, 16'hA5A5, 16'h0000};
        vec[2]  = '{1'b0, 1'b0, 3'd3, 16'h0000, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5};
        vec[3]  = '{1'b0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd3, 16'h1234, 16'hA5A5};
        vec[4]  = '{1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'h1234};
        vec[5]  = '{1'b0, 1'b1, 3'd1, 16'h0001, 3'd0, 3'd1, 16'h0000, 16'h0001};
        vec[6]  = '{1'b0, 1'b1, 3'd2, 16'h0002, 3'd1, 3'd2, 16'h0001, 16'h0002};
        vec[7]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 16'h0001, 16'h0002};
        vec[8]  = '{1'b0, 1'b1, 3'd7, 16'hCAFE, 3'd7, 3'd6, 16'hCAFE, 16'h0000};
        vec[9]  = '{1'b0, 1'b0, 3'd7, 16'h0000, 3'd7, 3'd0, 16'hCAFE, 16'h0000};
        vec[10] = '{1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd5, 16'hA5A5, 16'h1234};
        vec[11] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'h0000, 16'h0000};
        vec[12] = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd1, 16'h0000, 16'h0000};

        for (int i = 0; i < 13; i++) begin
            R = vec[i].r; WE = vec[i].we; WA = vec[i].wa; WD = vec[i].wd;
            RA1 = vec[i].ra1; RA2 = vec[i].ra2;
            #2;
            check($sformatf("vec%0d_rd1", i), rd1_a, vec[i].e1);
            check($sformatf("vec%0d_rd2", i), rd2_a, vec[i].e2);
            tick();
        end
        R = 1'b0; WE = 1'b0;

        // No forwarding: old value in the write cycle, new value after the edge
        do_reset();
        WE = 1'b1; WA = 3'd5; WD = 16'h1234; RA1 = 3'd5; RA2 = 3'd0;
        #2;
        check("nobyp_same_cycle", rd1_nb, 16'h0000);
        check("byp_same_cycle", rd1_a, 16'h1234);
        tick();
        WE = 1'b0;
        #2;
        check("nobyp_after_edge", rd1_nb, 16'h1234);

        // Register 0 writable only when not hardwired
        WE = 1'b1; WA = 3'd0; WD = 16'hFFFF; RA1 = 3'd0;
        #2;
        check("nozero_r0_bypass", rd1_nz, 16'hFFFF);
        check("zero_r0_no_bypass", rd1_a, 16'h0000);
        tick();
        WE = 1'b0;
        #2;
        check("nozero_r0_stored", rd1_nz, 16'hFFFF);
        check("zero_r0_stored", rd1_a, 16'h0000);

        // Reset with a simultaneous write, then a write on the first free edge
        do_reset();
        for (int i = 1; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
        RA1 = 3'd7; RA2 = 3'd4;
        #2;
        check("fill_r7", rd1_a, 16'h7777);
        check("fill_r4", rd2_a, 16'h4444);
        R = 1'b1; WE = 1'b1; WA = 3'd2; WD = 16'hBEEF; RA1 = 3'd2; RA2 = 3'd2;
        #2;
        check("reset_cycle_no_bypass", rd1_a, 16'h2222);
        tick();
        R = 1'b0; WE = 1'b1; WA = 3'd4; WD = 16'h4004; RA1 = 3'd2; RA2 = 3'd4;
        #2;
        check("post_reset_r2", rd1_a, 16'h0000);
        check("post_reset_wr_bypass", rd2_a, 16'h4004);
        tick();
        WE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp;
            exp = (i == 4) ? 16'h4004 : 16'h0000;
            RA1 = 3'(i); RA2 = 3'(i);
            #2;
            check($sformatf("after_reset_rd1_a%0d", i), rd1_a, exp);
            check($sformatf("after_reset_rd2_a%0d", i), rd2_a, exp);
            check($sformatf("after_reset_nz_a%0d", i), rd1_nz, exp);
            tick();
        end

        // Out-of-range addresses at DEPTH=6
        do_reset();
        for (int i = 0; i < 6; i++) wr(3'(i), 16'(16'h0100 + i));
        WE = 1'b1; WA = 3'd7; WD = 16'hCAFE; RA1 = 3'd7; RA2 = 3'd6;
        #2;
        check("d6_oor_no_bypass", rd1_d6, 16'h0000);
        tick();
        WA = 3'd6;
        tick();
        WE = 1'b0;
        #2;
        check("d6_read7", rd1_d6, 16'h0000);
        check("d6_read6", rd2_d6, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] exp;
            exp = (i == 0) ? 16'h0000 : 16'(16'h0100 + i);
            RA1 = 3'(i); RA2 = 3'(5 - i);
            #2;
            check($sformatf("d6_keep_r%0d", i), rd1_d6, exp);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits, range 1 to 64.
REQ-002 SHALL have parameter DEPTH, default 8: number of registers, range 2 to 64.
REQ-003 SHALL have parameter AW, default 3: address width, at least ceil(log2(DEPTH)).
REQ-004 SHALL have parameter BYPASS, default 1: 1 = write-through forwarding to read ports, 0 = none.
REQ-005 SHALL have parameter ZERO_R0, default 1: 1 = register 0 hardwired to zero.
REQ-006 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port R, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port WE, input, 1 bit: write enable.
REQ-009 SHALL have port WA, input, AW bits: write address.
REQ-010 SHALL have port WD, input, WIDTH bits: write data.
REQ-011 SHALL have port RA1, input, AW bits: read address, port 1.
REQ-012 SHALL have port RA2, input, AW bits: read address, port 2.
REQ-013 SHALL have port RD1, output, WIDTH bits: read data, port 1.
REQ-014 SHALL have port RD2, output, WIDTH bits: read data, port 2.

Function
REQ-015 SHALL make reads combinational: RDn reflects register[RAn] in the same cycle, zero-cycle latency.
REQ-016 SHALL load WD into register[WA] on the rising CLK edge when WE=1 and R=0; all other registers hold.
REQ-017 SHALL hold every register at its current value on a rising edge when WE=0 and R=0.
REQ-018 SHALL make RDn equal WD combinationally when BYPASS=1, WE=1, R=0 and RAn==WA, so a read in the write cycle returns new data.
REQ-019 SHALL make RDn return the pre-write value when BYPASS=0 and RAn==WA; the new value appears the cycle after the edge.
REQ-020 SHALL, when ZERO_R0=1, ignore writes to address 0, read address 0 as all-zero, and apply no bypass for address 0.
REQ-021 SHALL ignore writes to any address >= DEPTH and return all-zero on reads from any address >= DEPTH.
REQ-022 SHALL allow both read ports to address the same or different registers concurrently, with no interaction between them.
REQ-023 SHALL truncate or extend nothing: the stored width equals WIDTH exactly.

Reset
REQ-024 SHALL clear every register to 0 on a rising edge with R=1, independent of WE, WA and WD.
REQ-025 SHALL give reset priority over a simultaneous write: the write is dropped.
REQ-026 SHALL suppress bypass while R=1, so RDn reflects stored contents only.
REQ-027 SHALL make RD1 and RD2 read 0 for every in-range address in the cycle after reset.
REQ-028 SHALL, if reset is asserted mid-sequence, start the first write after R falls on the first rising edge with R=0.

Structure
REQ-029 SHALL place the default WIDTH, DEPTH and AW constants in the shared processor package, alongside the ISA register-count constants.
REQ-030 SHALL be built from one sub-module, reg_word: a WIDTH-bit rising-edge register with synchronous active-high reset and load enable, instantiated DEPTH times.
REQ-031 SHALL implement the write-address decode and the two read multiplexers in reg_file itself, not in reg_word.

Verification
Each scenario runs at WIDTH=16, DEPTH=8 unless it states otherwise.
REQ-032 SHALL cover basic write/read: write 0xA5A5 to reg 3, then set RA1=3 and RA2=3 -> RD1=RD2=0xA5A5 on the following cycle.
REQ-033 SHALL cover bypass: in the same cycle WE=1, WA=5, WD=0x1234 and RA1=5 -> RD1=0x1234 before the edge; with BYPASS=0 -> RD1 shows the old value 0x0000.
REQ-034 SHALL cover register 0: write 0xFFFF to reg 0 with ZERO_R0=1 -> RD1=0x0000 with RA1=0; with ZERO_R0=0 -> RD1=0xFFFF.
REQ-035 SHALL cover reset: fill regs 1-7 with 0x1111-0x7777, then assert R=1 together with WE=1, WA=2, WD=0xBEEF for one edge -> all reads return 0x0000.
REQ-036 SHALL cover out-of-range addresses at DEPTH=6, AW=3: write 0xCAFE to address 7 -> RA1=7 returns 0x0000 and regs 0-5 are unchanged.
REQ-037 SHALL cover dual-port independence: after writing reg 1=0x0001 and reg 2=0x0002, set RA1=1 and RA2=2 -> RD1=0x0001 and RD2=0x0002 in the same cycle.
